// File: rtl/elevator_fsm.sv
// Single-car elevator controller: one-floor moves on up/down requests, then a door open/hold/close cycle.
// Outputs are registered from the next state, so each output is in step with its state and has no glitches.
module elevator_fsm #(
  parameter int NUM_FLOORS        = 4,
  parameter int TRAVEL_CYCLES     = 3,
  parameter int DOOR_HOLD_CYCLES  = 4,
  parameter int DOOR_CLOSE_CYCLES = 2,
  parameter int DOOR_OPEN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_up,
  input  logic button_down,
  input  logic door_open,
  output logic elevator_motor_up,
  output logic elevator_motor_down,
  output logic door_motor_open,
  output logic door_motor_close
);

  localparam int FW   = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int TW   = $clog2(TRAVEL_CYCLES + 1);
  localparam int DMAX = (DOOR_OPEN_TIMEOUT > DOOR_HOLD_CYCLES) ?
                        ((DOOR_OPEN_TIMEOUT > DOOR_CLOSE_CYCLES) ? DOOR_OPEN_TIMEOUT : DOOR_CLOSE_CYCLES) :
                        ((DOOR_HOLD_CYCLES > DOOR_CLOSE_CYCLES) ? DOOR_HOLD_CYCLES : DOOR_CLOSE_CYCLES);
  localparam int DW   = $clog2(DMAX + 1);

  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_HOLD, DOOR_CLOSING
  } state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] floor, floor_nxt;
  logic [TW-1:0] travel_cnt, travel_nxt;
  logic [DW-1:0] door_cnt, door_nxt;
  logic          pending_up, pending_down, pend_up_nxt, pend_dn_nxt;
  logic          up_nxt, dn_nxt, open_nxt, close_nxt;
  logic          eff_up, eff_dn, at_top, at_bot;

  assign eff_up = button_up | pending_up;
  assign eff_dn = button_down | pending_down;
  assign at_top = (floor == TOP_FLOOR);
  assign at_bot = (floor == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      floor               <= '0;
      travel_cnt          <= '0;
      door_cnt            <= '0;
      pending_up          <= 1'b0;
      pending_down        <= 1'b0;
      elevator_motor_up   <= 1'b0;
      elevator_motor_down <= 1'b0;
      door_motor_open     <= 1'b0;
      door_motor_close    <= 1'b0;
    end else begin
      state               <= state_nxt;
      floor               <= floor_nxt;
      travel_cnt          <= travel_nxt;
      door_cnt            <= door_nxt;
      pending_up          <= pend_up_nxt;
      pending_down        <= pend_dn_nxt;
      elevator_motor_up   <= up_nxt;
      elevator_motor_down <= dn_nxt;
      door_motor_open     <= open_nxt;
      door_motor_close    <= close_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    floor_nxt   = floor;
    travel_nxt  = travel_cnt;
    door_nxt    = door_cnt;
    pend_up_nxt = pending_up | button_up;
    pend_dn_nxt = pending_down | button_down;
    case (state)
      IDLE: begin
        travel_nxt = '0;
        door_nxt   = '0;
        // A request that cannot be served from this floor still cycles the door.
        if (eff_up && !at_top) begin
          state_nxt   = MOVE_UP;
          pend_up_nxt = 1'b0;
        end else if (eff_dn && !at_bot) begin
          state_nxt   = MOVE_DOWN;
          pend_dn_nxt = 1'b0;
        end else if (eff_up || eff_dn) begin
          state_nxt   = DOOR_OPENING;
          pend_up_nxt = 1'b0;
          pend_dn_nxt = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_cnt == TW'(TRAVEL_CYCLES - 1)) begin
          state_nxt  = DOOR_OPENING;
          travel_nxt = '0;
          if (state == MOVE_UP && !at_top)
            floor_nxt = floor + FW'(1);
          else if (state == MOVE_DOWN && !at_bot)
            floor_nxt = floor - FW'(1);
        end else begin
          travel_nxt = travel_cnt + TW'(1);
        end
      end
      DOOR_OPENING: begin
        if (door_open) begin
          state_nxt = DOOR_HOLD;
          door_nxt  = '0;
        end else if (door_cnt == DW'(DOOR_OPEN_TIMEOUT - 1)) begin
          state_nxt = DOOR_CLOSING;
          door_nxt  = '0;
        end else begin
          door_nxt = door_cnt + DW'(1);
        end
      end
      DOOR_HOLD: begin
        if (door_cnt == DW'(DOOR_HOLD_CYCLES - 1)) begin
          state_nxt = DOOR_CLOSING;
          door_nxt  = '0;
        end else begin
          door_nxt = door_cnt + DW'(1);
        end
      end
      DOOR_CLOSING: begin
        if (door_cnt == DW'(DOOR_CLOSE_CYCLES - 1)) begin
          state_nxt = IDLE;
          door_nxt  = '0;
        end else begin
          door_nxt = door_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up_nxt    = (state_nxt == MOVE_UP);
    dn_nxt    = (state_nxt == MOVE_DOWN);
    open_nxt  = (state_nxt == DOOR_OPENING);
    close_nxt = (state_nxt == DOOR_CLOSING);
  end

endmodule

// File: tb/tb_elevator_fsm.sv
// Bench for elevator_fsm: directed trips and boundaries, then random traffic against a queue-based model.
module tb_elevator_fsm;

  localparam int NF      = 4;
  localparam int TRAVEL  = 3;
  localparam int HOLD    = 4;
  localparam int CLOSE   = 2;
  localparam int TIMEOUT = 16;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_UP   = 4'b1000;
  localparam logic [3:0] C_DN   = 4'b0100;
  localparam logic [3:0] C_OP   = 4'b0010;
  localparam logic [3:0] C_CL   = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic button_up = 1'b0, button_down = 1'b0, door_open = 1'b0;
  logic elevator_motor_up, elevator_motor_down, door_motor_open, door_motor_close;
  logic [3:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {elevator_motor_up, elevator_motor_down, door_motor_open, door_motor_close};

  always #5 clk = ~clk;

  elevator_fsm dut (
    .clk                 (clk),
    .reset               (reset),
    .button_up           (button_up),
    .button_down         (button_down),
    .door_open           (door_open),
    .elevator_motor_up   (elevator_motor_up),
    .elevator_motor_down (elevator_motor_down),
    .door_motor_open     (door_motor_open),
    .door_motor_close    (door_motor_close)
  );

  // Model: a queue of output codes still to be emitted plus the open-ended door-opening wait.
  int         m_floor = 0;
  bit         m_pu = 0, m_pd = 0;
  logic [3:0] m_cur = C_NONE;
  logic [3:0] q[$];
  int         m_open_cnt = 0;
  logic [3:0] exp_out = C_NONE;

  function automatic void model_step(bit r, bit u, bit d, bit o);
    bit eu, ed, start_open;
    start_open = 0;
    if (!r) begin
      m_floor = 0; m_pu = 0; m_pd = 0; q.delete();
      m_open_cnt = 0; exp_out = C_NONE;
    end else if (m_cur == C_NONE && q.size() == 0) begin
      eu = u | m_pu;
      ed = d | m_pd;
      m_pu = eu;
      m_pd = ed;
      if (eu && m_floor < NF - 1) begin
        m_pu = 0; m_floor++;
        repeat (TRAVEL) q.push_back(C_UP);
      end else if (ed && m_floor > 0) begin
        m_pd = 0; m_floor--;
        repeat (TRAVEL) q.push_back(C_DN);
      end else if (eu || ed) begin
        m_pu = 0; m_pd = 0; start_open = 1;
      end
      if (start_open) begin
        exp_out = C_OP; m_open_cnt = 1;
      end else if (q.size() > 0) begin
        exp_out = q.pop_front();
      end else begin
        exp_out = C_NONE;
      end
    end else begin
      m_pu |= u;
      m_pd |= d;
      if (q.size() > 0) begin
        exp_out = q.pop_front();
      end else if (m_cur == C_UP || m_cur == C_DN) begin
        exp_out = C_OP; m_open_cnt = 1;
      end else if (m_cur == C_OP) begin
        if (o) begin
          repeat (HOLD) q.push_back(C_NONE);
          repeat (CLOSE) q.push_back(C_CL);
          exp_out = q.pop_front();
        end else if (m_open_cnt == TIMEOUT) begin
          repeat (CLOSE) q.push_back(C_CL);
          exp_out = q.pop_front();
        end else begin
          exp_out = C_OP; m_open_cnt++;
        end
      end else begin
        exp_out = C_NONE;
      end
    end
    m_cur = exp_out;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic cycle(input string tag, input bit u, input bit d, input bit o, input bit r);
    @(negedge clk);
    reset = r; button_up = u; button_down = d; door_open = o;
    @(posedge clk);
    model_step(r, u, d, o);
    #1;
    check(tag, outs, exp_out);
    check("onehot", {3'b000, $countones(outs) <= 1}, 4'b0001);
  endtask

  task automatic idle_n(input string tag, input int n);
    repeat (n) cycle(tag, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset held with buttons active: everything stays quiet.
    for (int i = 0; i < 4; i++) cycle("reset_hold", 1, 1, 1, 0);
    idle_n("post_reset_idle", 3);

    // Up trip from floor 0, door pulse after two opening cycles.
    cycle("up_trip", 1, 0, 0, 1);
    idle_n("up_trip", 4);
    cycle("up_trip_door", 0, 0, 1, 1);
    idle_n("up_trip_tail", 9);

    // Down trip back to floor 0.
    cycle("down_trip", 0, 1, 0, 1);
    idle_n("down_trip", 5);
    cycle("down_trip_door", 0, 0, 1, 1);
    idle_n("down_trip_tail", 9);

    // Down at floor 0: door cycle only.
    cycle("down_at_bottom", 0, 1, 0, 1);
    idle_n("down_at_bottom", 2);
    cycle("bottom_door", 0, 0, 1, 1);
    idle_n("bottom_tail", 9);

    // Climb to floor 1, then both buttons together: up first, latched down second.
    cycle("to_floor1", 1, 0, 0, 1);
    idle_n("to_floor1", 4);
    cycle("to_floor1_door", 0, 0, 1, 1);
    idle_n("to_floor1_tail", 9);
    cycle("both_buttons", 1, 1, 0, 1);
    idle_n("prio_up", 4);
    cycle("prio_up_door", 0, 0, 1, 1);
    idle_n("prio_latched_down", 11);
    cycle("prio_down_door", 0, 0, 1, 1);
    idle_n("prio_tail", 9);

    // Door timeout: never assert door_open on a down trip to floor 0.
    cycle("timeout_trip", 0, 1, 0, 1);
    idle_n("timeout", TRAVEL + TIMEOUT + CLOSE + 3);

    // Climb to the top with timeouts, then up at the top floor does not move.
    for (int i = 0; i < NF - 1; i++) begin
      cycle("climb", 1, 0, 0, 1);
      idle_n("climb", TRAVEL + TIMEOUT + CLOSE + 2);
    end
    cycle("up_at_top", 1, 0, 0, 1);
    idle_n("up_at_top", TIMEOUT + CLOSE + 2);

    // Mid-move reset: motor drops without a clock edge, floor returns to 0.
    cycle("pre_reset", 0, 0, 0, 0);
    cycle("pre_reset", 0, 0, 0, 1);
    cycle("move_up_start", 1, 0, 0, 1);
    cycle("move_up_mid", 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", outs, C_NONE);
    cycle("reset_low", 0, 0, 0, 0);
    cycle("reset_release", 0, 0, 0, 1);
    cycle("floor0_after_reset", 0, 1, 0, 1);
    idle_n("floor0_after_reset", TIMEOUT + CLOSE + 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("random",
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 299) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_fsm.md
ELEVATOR_FSM -- requirements
Module: elevator_fsm

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_FLOORS, 4, floors served, numbered 0..NUM_FLOORS-1
- TRAVEL_CYCLES, 3, motor-on cycles per one-floor move
- DOOR_HOLD_CYCLES, 4, cycles the door stays open after the open sensor asserts
- DOOR_CLOSE_CYCLES, 2, close-motor cycles
- DOOR_OPEN_TIMEOUT, 16, maximum cycles spent waiting for the open sensor
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk input 1 single clock; all state changes on its rising edge
- reset input 1 asynchronous, active-low reset (0 = reset asserted)
- button_up input 1 request to move one floor up
- button_down input 1 request to move one floor down
- door_open input 1 door-fully-open sensor
- elevator_motor_up output 1 drive car upward
- elevator_motor_down output 1 drive car downward
- door_motor_open output 1 drive door open
- door_motor_close output 1 drive door closed
REQ-003 All outputs SHALL be registered Moore outputs.
REQ-004 At most one output SHALL be high in any cycle.

Function
REQ-005 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_HOLD and DOOR_CLOSING.
REQ-006 Internal state SHALL include a floor register, a travel counter, a door counter, and pending_up/pending_down latches.
REQ-007 Output map: MOVE_UP -> elevator_motor_up=1; MOVE_DOWN -> elevator_motor_down=1; DOOR_OPENING -> door_motor_open=1; DOOR_CLOSING -> door_motor_close=1; all other states -> all outputs 0.
REQ-008 IDLE transitions:
- effective up request (button_up or pending_up) with floor<NUM_FLOORS-1 -> MOVE_UP
- otherwise, effective down request with floor>0 -> MOVE_DOWN
- request that cannot move (up at top floor, down at floor 0) -> DOOR_OPENING with no motion
- consumed pending latch clears on the transition
REQ-009 Up has priority over down when both are effective in the same cycle; the down request stays latched as pending_down.
REQ-010 A button pulse of one cycle SHALL be sufficient to register a request.
REQ-011 MOVE_UP/MOVE_DOWN SHALL last exactly TRAVEL_CYCLES cycles, then floor increments/decrements by 1 and the FSM enters DOOR_OPENING.
REQ-012 DOOR_OPENING SHALL hold until door_open=1, then go to DOOR_HOLD.
REQ-013 DOOR_OPENING SHALL go to DOOR_CLOSING if DOOR_OPEN_TIMEOUT cycles elapse without door_open.
REQ-014 DOOR_HOLD SHALL last DOOR_HOLD_CYCLES cycles, then go to DOOR_CLOSING.
REQ-015 DOOR_CLOSING SHALL last DOOR_CLOSE_CYCLES cycles, then return to IDLE.
REQ-016 Button presses in any non-IDLE state SHALL set the matching pending latch; pending requests are served from IDLE in REQ-008 order.
REQ-017 door_open SHALL be ignored outside DOOR_OPENING.
REQ-018 The floor register SHALL saturate within 0..NUM_FLOORS-1 and never wrap.

Reset
REQ-019 reset=0 SHALL asynchronously force state=IDLE, floor=0, all counters=0, pending latches=0 and all outputs=0, including mid-move or mid-door-cycle.
REQ-020 After reset returns to 1, the FSM SHALL leave IDLE no earlier than the first rising edge on which a request is sampled.

Verification
REQ-021 Reset assertion: reset=0 with buttons active -> all outputs 0 and floor 0 for the whole assertion.
REQ-022 Up trip: at floor 0, one-cycle button_up pulse ->
- elevator_motor_up=1 for exactly 3 cycles
- then door_motor_open=1 until a door_open pulse is sampled
- then all outputs 0 for 4 cycles
- then door_motor_close=1 for 2 cycles, then IDLE with floor 1
REQ-023 Down trip: from floor 1, one-cycle button_down pulse -> elevator_motor_down=1 for 3 cycles, then the same door sequence as REQ-022, ending at floor 0.
REQ-024 Boundary and priority:
- button_down at floor 0 -> no motor motion, door cycle only
- button_up and button_down in the same cycle at floor 1 -> up trip first, then the latched down trip returns the car to floor 1
REQ-025 Door timeout: door_open held 0 -> door_motor_open=1 for exactly 16 cycles, then door_motor_close=1 for 2 cycles.
REQ-026 Mid-operation reset: reset=0 during MOVE_UP -> elevator_motor_up drops to 0 immediately, without waiting for a clock edge, and the floor stays 0.
